// File: rtl/control_word_buffer_pkg.sv
// Shared control-unit definitions: default field widths, the NOP word and the
// occupancy encoding used by the control word buffer.
package control_word_buffer_pkg;

  localparam int unsigned CU_CW_W    = 38;
  localparam int unsigned CU_STATE_W = 10;
  localparam int unsigned CU_N_W     = 3;
  localparam int unsigned CU_CR_W    = 10;
  localparam int unsigned CU_CNT_W   = 8;

  localparam logic [CU_CW_W-1:0] CU_NOP_WORD = '0;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Number of words held in a given occupancy state.
  function automatic logic [1:0] occ_count(occ_e s);
    logic [1:0] n;
    n = 2'd0;
    if (s == OCC_ONE) n = 2'd1;
    if (s == OCC_TWO) n = 2'd2;
    return n;
  endfunction

endpackage

// File: rtl/control_word_buffer_sat_counter.sv
// Saturating up-counter that adds a small increment each cycle and sticks at
// its all-ones value; cleared only by reset.
module sat_counter #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned INC_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [INC_W-1:0] inc,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [SUM_W-1:0] sum;

  // Widened sum so the overflow test cannot wrap.
  always_comb begin
    sum     = SUM_W'(count_q) + SUM_W'(inc);
    count_d = count_q;
    if (sum > SUM_W'(CNT_MAX)) begin
      count_d = CNT_MAX;
    end else begin
      count_d = CNT_W'(sum);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/control_word_buffer.sv
// Registered control word stage with valid/ready handshake, a one-word skid
// slot, and a flush that empties the stage and counts the discarded words.
module control_word_buffer
  import control_word_buffer_pkg::*;
#(
  parameter int unsigned      CW_W     = CU_CW_W,
  parameter int unsigned      STATE_W  = CU_STATE_W,
  parameter int unsigned      N_W      = CU_N_W,
  parameter int unsigned      CR_W     = CU_CR_W,
  parameter logic [CW_W-1:0]  NOP_WORD = CW_W'(CU_NOP_WORD),
  parameter int unsigned      CNT_W    = CU_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CW_W-1:0]    in_word,
  input  logic [STATE_W-1:0] in_state,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CW_W-1:0]    out_word,
  output logic [STATE_W-1:0] out_state,
  output logic [N_W-1:0]     out_n,
  output logic [CR_W-1:0]    out_cr,
  output logic [CNT_W-1:0]   drop_count
);

  occ_e state_q;
  occ_e state_d;

  logic [CW_W-1:0]    head_word_q;
  logic [CW_W-1:0]    head_word_d;
  logic [STATE_W-1:0] head_state_q;
  logic [STATE_W-1:0] head_state_d;
  logic [CW_W-1:0]    skid_word_q;
  logic [CW_W-1:0]    skid_word_d;
  logic [STATE_W-1:0] skid_state_q;
  logic [STATE_W-1:0] skid_state_d;
  logic               valid_q;
  logic               valid_d;
  logic               ready_q;
  logic               ready_d;
  logic [1:0]         drop_inc;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid & ready_q;
  assign out_xfer = valid_q & out_ready;

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OCC_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy; flush always empties the stage.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: if (in_xfer) state_d = OCC_ONE;
        OCC_ONE: begin
          if (in_xfer && !out_xfer) begin
            state_d = OCC_TWO;
          end else if (!in_xfer && out_xfer) begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_TWO: if (out_xfer) state_d = OCC_ONE;
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  // Next head/skid contents, handshake flags and drop increment.
  always_comb begin
    head_word_d  = head_word_q;
    head_state_d = head_state_q;
    skid_word_d  = skid_word_q;
    skid_state_d = skid_state_q;
    drop_inc     = 2'd0;
    if (flush) begin
      head_word_d  = NOP_WORD;
      head_state_d = '0;
      // An output transfer coinciding with flush completes and is not a drop.
      drop_inc     = occ_count(state_q) + 2'(in_xfer) - 2'(out_xfer);
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (in_xfer) begin
            head_word_d  = in_word;
            head_state_d = in_state;
          end
        end
        OCC_ONE: begin
          if (in_xfer && !out_xfer) begin
            skid_word_d  = in_word;
            skid_state_d = in_state;
          end else if (in_xfer) begin
            head_word_d  = in_word;
            head_state_d = in_state;
          end else if (out_xfer) begin
            head_word_d  = NOP_WORD;
            head_state_d = '0;
          end
        end
        OCC_TWO: begin
          if (out_xfer) begin
            head_word_d  = skid_word_q;
            head_state_d = skid_state_q;
          end
        end
        default: begin
          head_word_d  = NOP_WORD;
          head_state_d = '0;
        end
      endcase
    end
    valid_d = (state_d != OCC_EMPTY);
    ready_d = (state_d != OCC_TWO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_word_q  <= NOP_WORD;
      head_state_q <= '0;
      skid_word_q  <= NOP_WORD;
      skid_state_q <= '0;
      valid_q      <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      head_word_q  <= head_word_d;
      head_state_q <= head_state_d;
      skid_word_q  <= skid_word_d;
      skid_state_q <= skid_state_d;
      valid_q      <= valid_d;
      ready_q      <= ready_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W),
    .INC_W (2)
  ) u_drop_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (drop_inc),
    .count (drop_count)
  );

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_word  = head_word_q;
  assign out_state = head_state_q;
  assign out_n     = head_word_q[CW_W-1 -: N_W];
  assign out_cr    = head_word_q[CR_W-1:0];

endmodule
